// File: rtl/pcie_refclk_monitor.sv
// PCIe reference clock buffer enable and frequency monitor: counts divided refclk edges
// per clk_125 window and qualifies refclk_ok with lock/loss hysteresis.
module pcie_refclk_monitor #(
  parameter int WINDOW    = 1024,
  parameter int CNT_W     = 16,
  parameter int EXP_MIN   = 48,
  parameter int EXP_MAX   = 54,
  parameter int LOCK_GOOD = 4,
  parameter int LOSS_BAD  = 2
) (
  input  logic             clk_125,
  input  logic             rst,
  input  logic             enable,
  input  logic             refclk_div,
  output logic             refck_pwdnb,
  output logic             refclk_ok,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             lol_pulse
);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int BAD_W  = $clog2(LOSS_BAD + 1);

  // state   | meaning
  // OFF     | buffer powered down, counters held at zero
  // SETTLE  | buffer powered, first window reported but ignored for lock
  // ACQUIRE | counting consecutive good windows toward lock
  // LOCKED  | refclk_ok high, counting consecutive bad windows toward loss
  typedef enum logic [1:0] {OFF, SETTLE, ACQUIRE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, sync_prev, edge_det;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt, cnt_final;
  logic [GOOD_W-1:0] good_run, good_nxt;
  logic [BAD_W-1:0]  bad_run, bad_nxt;
  logic              ok_nxt, lol_nxt, valid_nxt, terminal, win_good;

  assign refck_pwdnb = (state != OFF);
  assign terminal    = (win_cnt == WIN_W'(WINDOW - 1));
  // Edge seen in the terminal cycle still belongs to the closing window.
  assign cnt_final   = (edge_det && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign win_good    = (cnt_final >= CNT_W'(EXP_MIN)) && (cnt_final <= CNT_W'(EXP_MAX));

  always_comb begin
    state_nxt = state;
    good_nxt  = good_run;
    bad_nxt   = bad_run;
    ok_nxt    = refclk_ok;
    lol_nxt   = 1'b0;
    valid_nxt = 1'b0;
    if (!enable) begin
      state_nxt = OFF;
      ok_nxt    = 1'b0;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else begin
      case (state)
        OFF: state_nxt = SETTLE;
        SETTLE: begin
          if (terminal) begin
            valid_nxt = 1'b1;
            state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (terminal) begin
            valid_nxt = 1'b1;
            if (!win_good) begin
              good_nxt = '0;
            end else if (good_run >= GOOD_W'(LOCK_GOOD - 1)) begin
              good_nxt  = GOOD_W'(LOCK_GOOD);
              bad_nxt   = '0;
              ok_nxt    = 1'b1;
              state_nxt = LOCKED;
            end else begin
              good_nxt = good_run + GOOD_W'(1);
            end
          end
        end
        LOCKED: begin
          if (terminal) begin
            valid_nxt = 1'b1;
            if (win_good) begin
              bad_nxt = '0;
            end else if (bad_run >= BAD_W'(LOSS_BAD - 1)) begin
              good_nxt  = '0;
              bad_nxt   = '0;
              ok_nxt    = 1'b0;
              lol_nxt   = 1'b1;
              state_nxt = ACQUIRE;
            end else begin
              bad_nxt = bad_run + BAD_W'(1);
            end
          end
        end
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync_prev  <= 1'b0;
      edge_det   <= 1'b0;
      state      <= OFF;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      good_run   <= '0;
      bad_run    <= '0;
      refclk_ok  <= 1'b0;
      meas_valid <= 1'b0;
      meas_count <= '0;
      lol_pulse  <= 1'b0;
    end else begin
      sync1      <= refclk_div;
      sync2      <= sync1;
      sync_prev  <= sync2;
      edge_det   <= sync2 & ~sync_prev;
      state      <= state_nxt;
      good_run   <= good_nxt;
      bad_run    <= bad_nxt;
      refclk_ok  <= ok_nxt;
      meas_valid <= valid_nxt;
      lol_pulse  <= lol_nxt;
      if (valid_nxt) meas_count <= cnt_final;
      if (!enable || (state == OFF)) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        edge_cnt <= terminal ? '0 : cnt_final;
      end
    end
  end
endmodule

// File: tb/tb_pcie_refclk_monitor.sv
// Directed bench for pcie_refclk_monitor: per-window vector table plus hand-written
// sequences for idle, disable mid-window, disable on terminal cycle and mid-run reset.
module tb_pcie_refclk_monitor;
  logic        clk_125 = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        refclk_div = 1'b0;
  logic        refck_pwdnb, refclk_ok, meas_valid, lol_pulse;
  logic [15:0] meas_count;

  int checks = 0;
  int errors = 0;
  int sq_half = 0;
  int burst_n = 0;
  int bcyc = 0;
  int ph = 0;
  int cyc = 0;

  always #4 clk_125 = ~clk_125;

  pcie_refclk_monitor dut (
    .clk_125    (clk_125),
    .rst        (rst),
    .enable     (enable),
    .refclk_div (refclk_div),
    .refck_pwdnb(refck_pwdnb),
    .refclk_ok  (refclk_ok),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .lol_pulse  (lol_pulse)
  );

  typedef struct {
    int half;
    int burst;
    int cmin;
    int cmax;
    bit ok;
    bit lol;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl[NVEC];

  // Square wave with half-period sq_half, or burst_n pulses (4 high / 4 low) from window start.
  task automatic step();
    if (sq_half > 0) refclk_div = ((ph / sq_half) % 2) == 1;
    else if (bcyc < burst_n * 8) refclk_div = (bcyc % 8) < 4;
    else refclk_div = 1'b0;
    ph++;
    bcyc++;
    @(posedge clk_125);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run_window(output int cnt, output int ok, output int lols, output int seen);
    cnt = 0; ok = 0; lols = 0; seen = 0;
    for (int i = 0; i < 1100 && seen == 0; i++) begin
      step();
      if (lol_pulse) lols++;
      if (meas_valid) begin
        seen = 1;
        cnt  = int'(meas_count);
        ok   = int'(refclk_ok);
      end
    end
  endtask

  initial begin
    int cnt, ok, lols, seen, cyc_en, nv, npw, nok, nlol;

    for (int i = 0; i < 5; i++) tbl[i] = '{10, 0, 51, 52, (i == 4), 1'b0};
    tbl[5]  = '{0, 0, 0, 1, 1'b1, 1'b0};
    tbl[6]  = '{0, 0, 0, 0, 1'b0, 1'b1};
    tbl[7]  = '{0, 48, 48, 48, 1'b0, 1'b0};
    tbl[8]  = '{0, 54, 54, 54, 1'b0, 1'b0};
    tbl[9]  = '{0, 47, 47, 47, 1'b0, 1'b0};
    tbl[10] = '{0, 48, 48, 48, 1'b0, 1'b0};
    tbl[11] = '{0, 54, 54, 54, 1'b0, 1'b0};
    tbl[12] = '{0, 48, 48, 48, 1'b0, 1'b0};
    tbl[13] = '{0, 54, 54, 54, 1'b1, 1'b0};
    tbl[14] = '{0, 55, 55, 55, 1'b1, 1'b0};
    tbl[15] = '{0, 48, 48, 48, 1'b1, 1'b0};
    tbl[16] = '{0, 55, 55, 55, 1'b1, 1'b0};
    tbl[17] = '{0, 55, 55, 55, 1'b0, 1'b1};
    tbl[18] = '{5, 0, 101, 104, 1'b0, 1'b0};
    for (int i = 19; i < 23; i++) tbl[i] = '{5, 0, 102, 103, 1'b0, 1'b0};
    tbl[23] = '{0, 50, 50, 51, 1'b0, 1'b0};
    tbl[24] = '{0, 50, 50, 50, 1'b0, 1'b0};
    tbl[25] = '{0, 50, 50, 50, 1'b0, 1'b0};
    tbl[26] = '{0, 50, 50, 50, 1'b1, 1'b0};

    // Reset and idle
    for (int i = 0; i < 4; i++) step();
    chk("rst_pwdnb", int'(refck_pwdnb), 0);
    chk("rst_ok", int'(refclk_ok), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_count", int'(meas_count), 0);
    chk("rst_lol", int'(lol_pulse), 0);
    rst = 1'b0;
    nv = 0; npw = 0; nok = 0; nlol = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (meas_valid) nv++;
      if (refck_pwdnb) npw++;
      if (refclk_ok) nok++;
      if (lol_pulse) nlol++;
    end
    chk("idle_valid_pulses", nv, 0);
    chk("idle_pwdnb_cycles", npw, 0);
    chk("idle_ok_cycles", nok, 0);
    chk("idle_lol_pulses", nlol, 0);

    // Enable and per-window table
    sq_half = tbl[0].half;
    enable = 1'b1;
    cyc_en = cyc;
    step();
    chk("pwdnb_rise", int'(refck_pwdnb), 1);
    for (int i = 0; i < NVEC; i++) begin
      sq_half = tbl[i].half;
      burst_n = tbl[i].burst;
      bcyc = 0;
      run_window(cnt, ok, lols, seen);
      chk($sformatf("win%0d_seen", i), seen, 1);
      chk_rng($sformatf("win%0d_count", i), cnt, tbl[i].cmin, tbl[i].cmax);
      chk($sformatf("win%0d_ok", i), ok, int'(tbl[i].ok));
      chk($sformatf("win%0d_lol_pulses", i), lols, int'(tbl[i].lol));
      if (i == 4) chk("lock_time", cyc - cyc_en, 5121);
    end

    // Disable at window count 500 while locked
    sq_half = 0; burst_n = 50; bcyc = 0;
    for (int i = 0; i < 500; i++) step();
    chk("pre_dis_ok", int'(refclk_ok), 1);
    enable = 1'b0;
    step();
    chk("dis_pwdnb", int'(refck_pwdnb), 0);
    chk("dis_ok", int'(refclk_ok), 0);
    chk("dis_lol", int'(lol_pulse), 0);
    chk("dis_valid", int'(meas_valid), 0);
    chk("dis_count", int'(meas_count), 50);
    nv = 0; nlol = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (meas_valid) nv++;
      if (lol_pulse) nlol++;
    end
    chk("off_valid_pulses", nv, 0);
    chk("off_lol_pulses", nlol, 0);

    // Disable coincident with the SETTLE terminal cycle
    sq_half = 10; burst_n = 0;
    enable = 1'b1;
    for (int i = 0; i < 1024; i++) step();
    chk("term_pre_valid", int'(meas_valid), 0);
    enable = 1'b0;
    step();
    chk("term_dis_valid", int'(meas_valid), 0);
    chk("term_dis_count", int'(meas_count), 50);
    chk("term_dis_pwdnb", int'(refck_pwdnb), 0);

    // Reset mid-operation
    enable = 1'b1;
    for (int i = 0; i < 1200; i++) step();
    chk_rng("pre_rst_count", int'(meas_count), 51, 52);
    chk("pre_rst_pwdnb", int'(refck_pwdnb), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_pwdnb", int'(refck_pwdnb), 0);
    chk("mid_rst_count", int'(meas_count), 0);
    chk("mid_rst_valid", int'(meas_valid), 0);
    chk("mid_rst_ok", int'(refclk_ok), 0);
    rst = 1'b0;
    enable = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pcie_refclk_monitor.md
# pcie_refclk_monitor

Receive-side companion to the PCIe SERDES external reference clock buffer. It enables the buffer through `refck_pwdnb` and measures a divided copy of the buffered reference clock against the 125 MHz system clock. It declares the reference clock good or lost, and provides the `refclk_ok` qualifier that the PCIe reset sequencer waits on before releasing the SERDES/PCS resets.

## Interface
Parameters:
- `WINDOW`, 1024: measurement window length in `clk_125` cycles (power of two, ≥16).
- `CNT_W`, 16: width of the edge counter and `meas_count`.
- `EXP_MIN`, 48: minimum acceptable edge count per window.
- `EXP_MAX`, 54: maximum acceptable edge count per window.
- `LOCK_GOOD`, 4: consecutive good windows required to assert `refclk_ok`.
- `LOSS_BAD`, 2: consecutive bad windows, while locked, required to drop `refclk_ok`.

Ports:
- `clk_125` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: request to power the reference clock buffer and monitor it.
- `refclk_div` in 1: reference clock divided by 16, asynchronous to `clk_125`.
- `refck_pwdnb` out 1: reference clock buffer power-down bar (1 = powered).
- `refclk_ok` out 1: reference clock present and in range.
- `meas_valid` out 1: one-cycle pulse when `meas_count` updates.
- `meas_count` out CNT_W: edge count of the last completed window.
- `lol_pulse` out 1: one-cycle pulse when `refclk_ok` falls from LOCKED.

## Operation
- Input path: `refclk_div` passes through a 2-FF synchronizer, then an edge-detect register. A rising edge is a cycle where the synchronized value is 1 and the previous value is 0.
- Edge counter: increments on each detected edge and saturates at all-ones (no wrap).
- Window counter: runs 0..WINDOW-1 whenever the state is not OFF.
- Terminal cycle (window count = WINDOW-1):
  - `meas_count` ← edge count including any edge detected in this cycle.
  - The edge counter clears to 0.
  - `meas_valid` pulses.
- A window is "good" iff EXP_MIN ≤ count ≤ EXP_MAX (inclusive).
- FSM states:
  - OFF: `refck_pwdnb`=0; counters held at 0. `enable`=1 → SETTLE.
  - SETTLE: `refck_pwdnb`=1. The first window is discarded for lock purposes but still reported via `meas_valid`. At its end → ACQUIRE.
  - ACQUIRE: each good window increments the good-run counter; a bad window clears it. Good-run reaching LOCK_GOOD → LOCKED, with `refclk_ok`=1.
  - LOCKED: each bad window increments the bad-run counter; a good window clears it. Bad-run reaching LOSS_BAD → ACQUIRE, with `refclk_ok`=0, `lol_pulse`=1, and both run counters cleared.
- `enable`=0 in any state → OFF next cycle. Effects: `refclk_ok`=0, all counters cleared, `meas_count` holds its last value, no `lol_pulse`.
- Simultaneous `enable` deassertion and window terminal cycle: OFF wins; `meas_valid` is not issued.
- Run counters saturate at their thresholds.

## Timing
- Reset values: `refck_pwdnb`=0, `refclk_ok`=0, `meas_valid`=0, `meas_count`=0, `lol_pulse`=0. State = OFF.
- Reset mid-operation: the block returns to the reset values on the next edge, regardless of state.
- `refck_pwdnb` rises 1 cycle after `enable` is sampled high in OFF.
- The first window begins on the first SETTLE cycle.
- Input latency: 3 cycles from a `refclk_div` transition to the detected edge (2 synchronizer stages plus the edge register).
- `meas_valid` and the `meas_count` update occur in the cycle after the terminal cycle.
- `refclk_ok` and `lol_pulse` change in the same cycle as the `meas_valid` that completes the qualifying window.
- Minimum time to lock: (1 + LOCK_GOOD) × WINDOW + 1 cycles after `enable`, i.e. 5121 cycles with defaults.
- Minimum `refclk_div` high or low time for correct counting: 2 `clk_125` cycles.

## Test plan
- Reset/idle: assert `rst` for 4 cycles with `enable`=0. Required: all outputs 0, `refck_pwdnb`=0, and no `meas_valid` for 5000 cycles.
- Nominal lock: `enable`=1 and `refclk_div` period 20 cycles. Required:
  - `meas_count` ∈ {51, 52} on each pulse.
  - `refclk_ok` rises with the 5th `meas_valid`.
  - `lol_pulse` never asserts.
- Loss: after lock, hold `refclk_div` at 0. Required: `meas_count`=0 on the next two windows, then `refclk_ok`=0 and a single `lol_pulse`, both on the 2nd bad window.
- Out of range and boundaries: `refclk_div` period 10 cycles gives count ≈102, and `refclk_ok` stays 0. Forced counts of 47 and 55 must be bad; forced counts of 48 and 54 must be good.
- Glitch tolerance: while locked, inject one bad window between good windows. Required: `refclk_ok` stays 1 and the bad-run counter clears.
- Disable mid-window: deassert `enable` at window count 500 while LOCKED. Required: the next cycle has `refck_pwdnb`=0 and `refclk_ok`=0, with no `lol_pulse`, no `meas_valid`, and `meas_count` unchanged.
